grb_pixel_packer: RTL and testbench
===================================

GRB_PIXEL_PACKER -- requirements
Module: grb_pixel_packer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 64, meaning pixels per frame (2..64).
REQ-002 SHALL have parameter PIX_W, default 6, meaning pixel index width.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to stream one frame.
REQ-006 SHALL have port bright_shift  input  3  brightness attenuation (right-shift amount).
REQ-007 SHALL have port mem_rd_en  output  1  read strobe to channel memory.
REQ-008 SHALL have port mem_addr  output  8  read address {chan[1:0], pixel[5:0]}.
REQ-009 SHALL have port mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd_en.
REQ-010 SHALL have port px_data  output  24  packed pixel {G,R,B}, bit 23 first on the wire.
REQ-011 SHALL have port px_valid  output  1  px_data holds a pixel for the serializer.
REQ-012 SHALL have port px_ready  input  1  serializer accepts px_data this cycle.
REQ-013 SHALL have port busy  output  1  high from start acceptance until frame_done.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after last pixel transfer.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, PRESENT, DONE.
REQ-016 IDLE: start=1 SHALL latch bright_shift, clear pixel counter to 0, and enter FETCH next cycle; busy=1 from that cycle.
REQ-017 FETCH SHALL assert mem_rd_en for exactly 3 consecutive cycles with chan 0 (G), 1 (R), 2 (B) and mem_addr[5:0] = current pixel index.
REQ-018 Each returned byte SHALL be stored as mem_rdata >> latched bright_shift (logical, zero-fill; shift 7 leaves bit 7 only as bit 0).
REQ-019 Captured bytes SHALL go to px_data[23:16]=G, [15:8]=R, [7:0]=B.
REQ-020 px_valid SHALL rise the cycle the B byte is captured (4 cycles after start is sampled); FSM SHALL then be in PRESENT.
REQ-021 In PRESENT, px_data and px_valid SHALL remain stable while px_ready=0.
REQ-022 Transfer SHALL occur on a cycle with px_valid=1 and px_ready=1; px_valid SHALL drop the next cycle.
REQ-023 After transfer of pixel index < NUM_PIXELS-1, counter SHALL increment and FSM SHALL re-enter FETCH next cycle (no prefetch; 4-cycle gap minimum between transfers).
REQ-024 After transfer of pixel NUM_PIXELS-1, FSM SHALL enter DONE, pulse frame_done for one cycle, then return to IDLE with busy=0; counter SHALL not wrap into a new frame.
REQ-025 start while busy=1 (including DONE cycle) SHALL be ignored.
REQ-026 px_ready while px_valid=0 SHALL have no effect.
REQ-027 mem_rd_en SHALL never assert outside FETCH; mem_addr SHALL be 0 when mem_rd_en=0.
REQ-028 bright_shift changes mid-frame SHALL not affect the frame in progress.

Reset
REQ-029 rst=1 SHALL, at the next edge, force IDLE, px_valid=0, px_data=0, mem_rd_en=0, mem_addr=0, busy=0, frame_done=0, counter=0, latched shift=0.
REQ-030 rst SHALL take priority over start and px_ready, including mid-FETCH or mid-PRESENT; no frame_done SHALL be emitted for an aborted frame.

Verification
REQ-031 Single pixel fetch: NUM_PIXELS=64, mem G=0x10,R=0x20,B=0x30 at pixel 0, shift 0, start -> rd_en cycles 1-3, addrs 0x00,0x40,0x80, px_valid at cycle 4 with px_data=0x102030.
REQ-032 Backpressure: hold px_ready=0 for 10 cycles -> px_data/px_valid unchanged, no further mem_rd_en; ready=1 -> one transfer, fetch of pixel 1 starts next cycle.
REQ-033 Full frame with px_ready=1: exactly 64 transfers in pixel order 0..63, frame_done one cycle after transfer 63, busy low after, 192 total mem_rd_en cycles.
REQ-034 Brightness: bytes 0xFF, shift 3 -> px_data=0x1F1F1F; change shift mid-frame to 0 -> remaining pixels still 0x1F1F1F.
REQ-035 Start while busy and reset mid-PRESENT: extra start ignored (still 64 transfers); rst at pixel 20 -> all outputs 0 next cycle, no frame_done, new start fetches pixel 0.

Source files
------------

// File: rtl/grb_pixel_packer.sv
// Fetches G, R and B bytes per pixel from channel memory, attenuates them by a
// per-frame brightness shift and presents packed {G,R,B} words to a serializer.
module grb_pixel_packer #(
    parameter int unsigned NUM_PIXELS = 64,
    parameter int unsigned PIX_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  bright_shift,
    output logic        mem_rd_en,
    output logic [7:0]  mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [23:0] px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned ADDR_PIX_W = 6;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } state_t;

    state_t           state;
    logic [PIX_W-1:0] pix_q;
    logic [2:0]       shift_q;
    logic [1:0]       step_q;
    logic [7:0]       g_q;
    logic [7:0]       r_q;
    logic [7:0]       scaled_c;

    assign scaled_c = mem_rdata >> shift_q;

    function automatic logic [7:0] addr_of(input logic [1:0] chan, input logic [PIX_W-1:0] pix);
        return {chan, ADDR_PIX_W'(pix)};
    endfunction

    // step_q sequences the three reads; each byte returns one cycle after its strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pix_q      <= '0;
            shift_q    <= '0;
            step_q     <= '0;
            g_q        <= '0;
            r_q        <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            px_data    <= '0;
            px_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        shift_q   <= bright_shift;
                        pix_q     <= '0;
                        step_q    <= '0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= addr_of(2'd0, '0);
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    step_q <= step_q + 2'd1;
                    case (step_q)
                        2'd0: mem_addr <= addr_of(2'd1, pix_q);
                        2'd1: begin
                            g_q      <= scaled_c;
                            mem_addr <= addr_of(2'd2, pix_q);
                        end
                        2'd2: begin
                            r_q       <= scaled_c;
                            mem_rd_en <= 1'b0;
                            mem_addr  <= '0;
                        end
                        default: begin
                            px_data  <= {g_q, r_q, scaled_c};
                            px_valid <= 1'b1;
                            state    <= PRESENT;
                        end
                    endcase
                end
                PRESENT: begin
                    if (px_ready) begin
                        px_valid <= 1'b0;
                        if (pix_q == LAST_PIX) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            pix_q     <= pix_q + PIX_W'(1);
                            step_q    <= '0;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= addr_of(2'd0, pix_q + PIX_W'(1));
                            state     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grb_pixel_packer.sv
// Randomized bench for grb_pixel_packer: a frame-level model predicts every pixel,
// read address, busy and frame_done; directed sequences cover latency, backpressure and reset.
module tb_grb_pixel_packer;

    localparam int unsigned NPIX = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  bright_shift;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        busy;
    logic        frame_done;

    grb_pixel_packer #(.NUM_PIXELS(NPIX), .PIX_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .bright_shift(bright_shift),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // channel memory: byte returned the cycle after the strobe, garbage otherwise
    logic [7:0] mem [256];
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

    // ready driver: 0 = hold low, 1 = hold high, 2 = random
    int ready_mode = 0;
    initial begin
        px_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 2) px_ready = 1'($urandom_range(0, 1));
            else                 px_ready = (ready_mode == 1);
        end
    end

    // frame-level reference model, sampled at the falling edge
    logic [23:0] exp_q[$];
    bit  mon_en  = 1'b0;
    bit  m_busy  = 1'b0;
    bit  m_done  = 1'b0;
    int  m_chan  = 0;
    int  m_pix   = 0;
    int  rd_cnt  = 0;
    int  xfer_cnt = 0;

    always @(negedge clk) begin
        bit done_next;
        logic [23:0] e;
        if (mon_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("rd_outside_frame", 32'(mem_rd_en & ~m_busy), 32'd0);
            if (mem_rd_en) begin
                rd_cnt++;
                check("rd_addr", 32'(mem_addr), 32'(m_chan * 64 + m_pix));
                m_chan = (m_chan == 2) ? 0 : m_chan + 1;
            end else begin
                check("idle_addr", 32'(mem_addr), 32'd0);
            end
            done_next = 1'b0;
            if (rst) begin
                exp_q.delete();
                m_busy = 1'b0;
                m_chan = 0;
            end else if (!m_busy) begin
                if (start) begin
                    for (int p = 0; p < int'(NPIX); p++)
                        exp_q.push_back({mem[p] >> bright_shift, mem[64 + p] >> bright_shift,
                                         mem[128 + p] >> bright_shift});
                    m_busy   = 1'b1;
                    m_chan   = 0;
                    m_pix    = 0;
                    rd_cnt   = 0;
                    xfer_cnt = 0;
                end
            end else if (m_done) begin
                m_busy = 1'b0;
            end else if (px_valid && px_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_transfer", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("px_data", 32'(px_data), 32'(e));
                    xfer_cnt++;
                    m_pix++;
                    if (exp_q.size() == 0) done_next = 1'b1;
                end
            end
            m_done = done_next;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit extra_starts);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            start = extra_starts && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        tick();
        start = 1'b0;
        check("frame_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bright_shift = 3'd0;
        fill_random();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(px_valid), 32'd0);
        check("rst_data", 32'(px_data), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // single pixel fetch latency, then backpressure
        mem[0] = 8'h10; mem[64] = 8'h20; mem[128] = 8'h30;
        pulse_start();
        @(negedge clk);
        check("c1_rd", 32'(mem_rd_en), 32'd1);
        check("c1_addr", 32'(mem_addr), 32'h00);
        @(negedge clk);
        check("c2_addr", 32'(mem_addr), 32'h40);
        @(negedge clk);
        check("c3_addr", 32'(mem_addr), 32'h80);
        @(negedge clk);
        check("c4_rd", 32'(mem_rd_en), 32'd0);
        check("c4_valid", 32'(px_valid), 32'd0);
        @(negedge clk);
        check("first_valid", 32'(px_valid), 32'd1);
        check("first_data", 32'(px_data), 32'h102030);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 32'(px_valid), 32'd1);
            check("bp_data", 32'(px_data), 32'h102030);
            check("bp_rd", 32'(mem_rd_en), 32'd0);
        end
        tick();
        ready_mode = 1;
        tick();
        ready_mode = 0;
        @(negedge clk);
        check("post_xfer_valid", 32'(px_valid), 32'd0);
        check("next_fetch_rd", 32'(mem_rd_en), 32'd1);
        check("next_fetch_addr", 32'(mem_addr), 32'h01);
        ready_mode = 1;
        wait_done(1000, 1'b0);
        check("frame_rd_cycles", 32'(rd_cnt), 32'd192);
        check("frame_transfers", 32'(xfer_cnt), 32'd64);
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);

        // brightness latched at start; mid-frame change must not leak in
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        tick();
        bright_shift = 3'd3;
        pulse_start();
        repeat (5) @(negedge clk);
        check("bright_data", 32'(px_data), 32'h1F1F1F);
        repeat (40) tick();
        bright_shift = 3'd0;
        wait_done(1000, 1'b0);
        check("bright_transfers", 32'(xfer_cnt), 32'd64);

        // random frames, random backpressure, stray starts while busy
        for (int f = 0; f < 3; f++) begin
            fill_random();
            tick();
            bright_shift = (f == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            ready_mode = 2;
            pulse_start();
            wait_done(3000, 1'b1);
            check("rand_transfers", 32'(xfer_cnt), 32'd64);
            check("rand_rd_cycles", 32'(rd_cnt), 32'd192);
        end

        // reset while pixel 20 is being presented
        fill_random();
        ready_mode = 1;
        pulse_start();
        for (int i = 0; i < 1000 && xfer_cnt < 20; i++) @(negedge clk);
        check("reach_px20", 32'(xfer_cnt), 32'd20);
        tick();
        ready_mode = 0;
        for (int i = 0; i < 20 && !px_valid; i++) @(negedge clk);
        check("px20_valid", 32'(px_valid), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(px_valid), 32'd0);
        check("abort_data", 32'(px_data), 32'd0);
        check("abort_rd", 32'(mem_rd_en), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        repeat (10) @(negedge clk);
        ready_mode = 1;
        pulse_start();
        @(negedge clk);
        check("restart_rd", 32'(mem_rd_en), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'h00);
        wait_done(1000, 1'b0);
        check("restart_transfers", 32'(xfer_cnt), 32'd64);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
